// File: rtl/tcm_lsu_master_pkg.sv
// Shared types and helpers for the TCM load/store initiator.
// The crossing-access behaviour is selected elsewhere by TCM_LSU_MISALIGN_SPLIT_EN.
package tcm_lsu_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10
  } size_t;

  typedef enum logic [2:0] {
    IDLE,
    ACC,
    WAIT,
    ACC2,
    WAIT2,
    RESP
  } state_t;

  // True when an access of this size starting at this byte lane spills into the next word.
  function automatic logic crosses_word(input logic [1:0] offset, input size_t size);
    case (size)
      SZ_H:    return offset == 2'd3;
      SZ_W:    return offset != 2'd0;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/tcm_lsu_master_if.sv
// Core-side request/response interface and TCM-side bus interface of the LSU.
interface tcm_lsu_core_if;
  logic        i_req;
  logic        o_ready;
  logic        i_we;
  logic [31:0] i_addr;
  logic [1:0]  i_size;
  logic        i_unsigned;
  logic [31:0] i_wdata;
  logic        o_rvalid;
  logic [31:0] o_rdata;
  logic        o_err;

  modport master (output i_req, i_we, i_addr, i_size, i_unsigned, i_wdata,
                  input  o_ready, o_rvalid, o_rdata, o_err);
  modport slave  (input  i_req, i_we, i_addr, i_size, i_unsigned, i_wdata,
                  output o_ready, o_rvalid, o_rdata, o_err);
endinterface

interface tcm_lsu_bus_if #(parameter int MEM_ADDR_WIDTH = 8);
  logic                      o_sel;
  logic [MEM_ADDR_WIDTH-1:0] o_addr;
  logic [3:0]                o_write;
  logic [31:0]               o_data;
  logic                      i_ack;
  logic [31:0]               i_data;

  modport master (output o_sel, o_addr, o_write, o_data,
                  input  i_ack, i_data);
  modport slave  (input  o_sel, o_addr, o_write, o_data,
                  output i_ack, i_data);
endinterface

// File: rtl/tcm_lsu_master_align.sv
// Combinational lane steering: store strobes/data for both halves of a split access,
// and load extraction with sign/zero extension from a (possibly merged) pair of words.
module tcm_lsu_align
  import tcm_lsu_pkg::*;
(
  input  logic [1:0]  st_offset,
  input  size_t       st_size,
  input  logic [31:0] st_wdata,
  output logic [3:0]  st_strb_lo,
  output logic [3:0]  st_strb_hi,
  output logic [31:0] st_data_lo,
  output logic [31:0] st_data_hi,
  input  logic [31:0] ld_word_lo,
  input  logic [31:0] ld_word_hi,
  input  logic [1:0]  ld_offset,
  input  size_t       ld_size,
  input  logic        ld_unsigned,
  output logic [31:0] ld_result
);

  logic [7:0]  strb_base;
  logic [31:0] wmask;
  logic [7:0]  strb_full;
  logic [63:0] data_full;
  logic [31:0] rword;

  always_comb begin
    strb_base = 8'h0F;
    wmask     = 32'hFFFF_FFFF;
    case (st_size)
      SZ_B: begin strb_base = 8'h01; wmask = 32'h0000_00FF; end
      SZ_H: begin strb_base = 8'h03; wmask = 32'h0000_FFFF; end
      default: ;
    endcase
    // Lanes past byte 3 belong to the following word.
    strb_full  = strb_base << st_offset;
    data_full  = {32'h0, st_wdata & wmask} << {st_offset, 3'b000};
    st_strb_lo = strb_full[3:0];
    st_strb_hi = strb_full[7:4];
    st_data_lo = data_full[31:0];
    st_data_hi = data_full[63:32];

    rword = 32'({ld_word_hi, ld_word_lo} >> {ld_offset, 3'b000});
    case (ld_size)
      SZ_B:    ld_result = ld_unsigned ? {24'h0, rword[7:0]}  : {{24{rword[7]}}, rword[7:0]};
      SZ_H:    ld_result = ld_unsigned ? {16'h0, rword[15:0]} : {{16{rword[15]}}, rword[15:0]};
      default: ld_result = rword;
    endcase
  end

endmodule

// File: rtl/tcm_lsu_master.sv
// Load/store initiator for the word-addressed TCM bus: one request per access, ack one cycle after sel.
// Define TCM_LSU_MISALIGN_SPLIT_EN to split word-crossing accesses into two bus cycles.
module tcm_lsu_master
  import tcm_lsu_pkg::*;
#(
  parameter int MEM_ADDR_WIDTH = 8
) (
  input  logic           i_clk,
  input  logic           i_reset,
  tcm_lsu_core_if.slave  core,
  tcm_lsu_bus_if.master  bus
);

`ifdef TCM_LSU_MISALIGN_SPLIT_EN
  localparam bit SPLIT_EN = 1'b1;
`else
  localparam bit SPLIT_EN = 1'b0;
`endif

  state_t                    state_q;
  logic                      we_q;
  logic [1:0]                off_q;
  size_t                     size_q;
  logic                      uns_q;
  logic [31:0]               wdata_q;
  logic [MEM_ADDR_WIDTH-1:0] waddr_q;
  logic [31:0]               word0_q;

  logic                      ready_q, rvalid_q, err_q, sel_q;
  logic [31:0]               rdata_q, data_q;
  logic [MEM_ADDR_WIDTH-1:0] addr_q;
  logic [3:0]                write_q;

  logic        idle;
  size_t       in_size;
  logic        in_illegal;
  logic [1:0]  st_off;
  size_t       st_size;
  logic [31:0] st_wdata;
  logic [3:0]  strb_lo, strb_hi;
  logic [31:0] sdata_lo, sdata_hi;
  logic [31:0] ld_lo, ld_result;
  logic        unused_addr_hi;

  assign unused_addr_hi = ^core.i_addr[31:MEM_ADDR_WIDTH+2];

  assign idle       = (state_q == IDLE);
  assign in_size    = size_t'(core.i_size);
  assign in_illegal = (core.i_size == 2'b11) ||
                      (!SPLIT_EN && crosses_word(core.i_addr[1:0], in_size));

  // Store lanes come from the live request at accept and from the captured one afterwards.
  assign st_off   = idle ? core.i_addr[1:0] : off_q;
  assign st_size  = idle ? in_size          : size_q;
  assign st_wdata = idle ? core.i_wdata     : wdata_q;
  assign ld_lo    = (state_q == WAIT2) ? word0_q : bus.i_data;

  tcm_lsu_align u_align (
    .st_offset   (st_off),
    .st_size     (st_size),
    .st_wdata    (st_wdata),
    .st_strb_lo  (strb_lo),
    .st_strb_hi  (strb_hi),
    .st_data_lo  (sdata_lo),
    .st_data_hi  (sdata_hi),
    .ld_word_lo  (ld_lo),
    .ld_word_hi  (bus.i_data),
    .ld_offset   (off_q),
    .ld_size     (size_q),
    .ld_unsigned (uns_q),
    .ld_result   (ld_result)
  );

  // Request capture: data fields only, no reset needed
  always_ff @(posedge i_clk) begin
    if (idle && core.i_req) begin
      we_q    <= core.i_we;
      off_q   <= core.i_addr[1:0];
      size_q  <= in_size;
      uns_q   <= core.i_unsigned;
      wdata_q <= core.i_wdata;
      waddr_q <= core.i_addr[MEM_ADDR_WIDTH+1:2];
    end
    if (state_q == WAIT && bus.i_ack) word0_q <= bus.i_data;
  end

  // FSM and registered outputs
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q  <= IDLE;
      ready_q  <= 1'b1;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      sel_q    <= 1'b0;
      addr_q   <= '0;
      write_q  <= '0;
      data_q   <= '0;
    end else begin
      sel_q    <= 1'b0;
      rvalid_q <= 1'b0;
      case (state_q)
        IDLE: if (core.i_req) begin
          ready_q <= 1'b0;
          if (in_illegal) begin
            state_q  <= RESP;
            rvalid_q <= 1'b1;
            err_q    <= 1'b1;
            rdata_q  <= '0;
          end else begin
            state_q <= ACC;
            sel_q   <= 1'b1;
            addr_q  <= core.i_addr[MEM_ADDR_WIDTH+1:2];
            write_q <= core.i_we ? strb_lo : 4'b0000;
            data_q  <= core.i_we ? sdata_lo : 32'h0;
          end
        end
        ACC: begin
          state_q <= WAIT;
          write_q <= '0;
        end
        WAIT: if (bus.i_ack) begin
          if (SPLIT_EN && crosses_word(off_q, size_q)) begin
            state_q <= ACC2;
            sel_q   <= 1'b1;
            addr_q  <= MEM_ADDR_WIDTH'(waddr_q + 1'b1);
            write_q <= we_q ? strb_hi : 4'b0000;
            data_q  <= we_q ? sdata_hi : 32'h0;
          end else begin
            state_q  <= RESP;
            rvalid_q <= 1'b1;
            err_q    <= 1'b0;
            rdata_q  <= we_q ? 32'h0 : ld_result;
          end
        end
        ACC2: begin
          state_q <= WAIT2;
          write_q <= '0;
        end
        WAIT2: if (bus.i_ack) begin
          state_q  <= RESP;
          rvalid_q <= 1'b1;
          err_q    <= 1'b0;
          rdata_q  <= we_q ? 32'h0 : ld_result;
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign core.o_ready  = ready_q;
  assign core.o_rvalid = rvalid_q;
  assign core.o_rdata  = rdata_q;
  assign core.o_err    = err_q;
  assign bus.o_sel     = sel_q;
  assign bus.o_addr    = addr_q;
  assign bus.o_write   = write_q;
  assign bus.o_data    = data_q;

endmodule

// File: tb/tb_tcm_lsu_master.sv
// Directed bench for tcm_lsu_master with a TCM model, response scoreboard and bus-access log.
module tb_tcm_lsu_master;
  localparam int MAW = 8;
`ifdef TCM_LSU_MISALIGN_SPLIT_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif

  typedef struct packed {
    logic [MAW-1:0] addr;
    logic [3:0]     strb;
    logic [31:0]    data;
  } bus_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } resp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_assert = 0;
  int   n_fail = 0;

  logic        mem_init = 1'b1;
  logic        ack_en = 1'b1;
  logic        spur_ack = 1'b0;
  logic        ack_q = 1'b0;
  logic [31:0] rd_q = '0;
  logic [31:0] mem [0:(1<<MAW)-1];

  bus_t  bus_log [$];
  bus_t  exp_bus [$];
  resp_t sb [$];

  tcm_lsu_core_if core_if ();
  tcm_lsu_bus_if #(.MEM_ADDR_WIDTH(MAW)) bus_if ();

  tcm_lsu_master #(.MEM_ADDR_WIDTH(MAW)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .core    (core_if),
    .bus     (bus_if)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign bus_if.i_ack  = ack_q | spur_ack;
  assign bus_if.i_data = rd_q;

  // TCM model: one-cycle ack, byte-strobed writes
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < (1 << MAW); i++) mem[i] <= 32'h0;
      mem[0] <= 32'hBEEF_CAFE;
      mem[1] <= 32'h1234_80FF;
      mem[2] <= 32'h4433_2211;
      mem[3] <= 32'h8877_6655;
    end else if (bus_if.o_sel) begin
      rd_q <= mem[bus_if.o_addr];
      for (int b = 0; b < 4; b++)
        if (bus_if.o_write[b]) mem[bus_if.o_addr][8*b +: 8] <= bus_if.o_data[8*b +: 8];
    end
    ack_q <= bus_if.o_sel && ack_en;
  end

  always @(negedge clk)
    if (bus_if.o_sel) bus_log.push_back({bus_if.o_addr, bus_if.o_write, bus_if.o_data});

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_bus(input logic [MAW-1:0] a, input logic [3:0] s, input logic [31:0] d);
    exp_bus.push_back({a, s, d});
  endtask

  task automatic do_req(input string tag, input logic we, input logic [31:0] addr,
                        input logic [1:0] size, input logic uns, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat);
    resp_t r;
    bus_t  got, want;
    int    acc;
    bit    seen;
    sb.push_back({exp_rdata, exp_err});
    bus_log.delete();
    @(negedge clk);
    check({tag, "_ready_idle"}, core_if.o_ready, 1);
    core_if.i_req = 1'b1; core_if.i_we = we; core_if.i_addr = addr;
    core_if.i_size = size; core_if.i_unsigned = uns; core_if.i_wdata = wdata;
    @(posedge clk); #1;
    acc = cyc;
    core_if.i_req = 1'b0; core_if.i_we = ~we; core_if.i_addr = $urandom;
    core_if.i_size = 2'($urandom); core_if.i_unsigned = ~uns; core_if.i_wdata = $urandom;
    check({tag, "_ready_busy"}, core_if.o_ready, 0);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (core_if.o_rvalid) begin seen = 1'b1; break; end
      @(posedge clk); #1;
    end
    check({tag, "_rvalid_seen"}, seen, 1);
    r = sb.pop_front();
    if (seen) begin
      check({tag, "_latency"}, cyc - acc + 1, exp_lat);
      check({tag, "_rdata"}, core_if.o_rdata, r.rdata);
      check({tag, "_err"}, core_if.o_err, r.err);
      @(posedge clk); #1;
      check({tag, "_rvalid_pulse"}, core_if.o_rvalid, 0);
    end
    check({tag, "_nsel"}, bus_log.size(), exp_bus.size());
    while (exp_bus.size() > 0 && bus_log.size() > 0) begin
      got = bus_log.pop_front();
      want = exp_bus.pop_front();
      check({tag, "_bus_addr"}, got.addr, want.addr);
      check({tag, "_bus_strb"}, got.strb, want.strb);
      check({tag, "_bus_data"}, got.data, want.data);
    end
    exp_bus.delete();
  endtask

  initial begin
    bit seen;
    core_if.i_req = 1'b0; core_if.i_we = 1'b0; core_if.i_addr = '0;
    core_if.i_size = '0; core_if.i_unsigned = 1'b0; core_if.i_wdata = '0;
    repeat (3) @(posedge clk);
    mem_init = 1'b0;
    #1;
    check("rst_ready", core_if.o_ready, 1);
    check("rst_rvalid", core_if.o_rvalid, 0);
    check("rst_rdata", core_if.o_rdata, 0);
    check("rst_err", core_if.o_err, 0);
    check("rst_sel", bus_if.o_sel, 0);
    check("rst_addr", bus_if.o_addr, 0);
    check("rst_write", bus_if.o_write, 0);
    check("rst_data", bus_if.o_data, 0);
    @(negedge clk); rst = 1'b0;

    push_bus(8'd1, 4'b0000, 32'h0); do_req("lb5",  0, 32'h5, 2'b00, 0, 0, 32'hFFFF_FF80, 0, 3);
    push_bus(8'd1, 4'b0000, 32'h0); do_req("lbu5", 0, 32'h5, 2'b00, 1, 0, 32'h0000_0080, 0, 3);
    push_bus(8'd0, 4'b0000, 32'h0); do_req("lh2",  0, 32'h2, 2'b01, 0, 0, 32'hFFFF_BEEF, 0, 3);
    push_bus(8'd0, 4'b0000, 32'h0); do_req("lhu2", 0, 32'h2, 2'b01, 1, 0, 32'h0000_BEEF, 0, 3);
    push_bus(8'd0, 4'b0000, 32'h0); do_req("lw0",  0, 32'h0, 2'b10, 1, 0, 32'hBEEF_CAFE, 0, 3);

    push_bus(8'd1, 4'b0100, 32'h00A5_0000); do_req("sb6", 1, 32'h6, 2'b00, 0, 32'h0000_00A5, 0, 0, 3);
    push_bus(8'd1, 4'b0000, 32'h0);         do_req("lw4", 0, 32'h4, 2'b10, 0, 0, 32'h12A5_80FF, 0, 3);
    push_bus(8'd3, 4'b1100, 32'hCAFE_0000); do_req("shE", 1, 32'hE, 2'b01, 0, 32'h0000_CAFE, 0, 0, 3);
    push_bus(8'd3, 4'b0000, 32'h0);         do_req("lwC", 0, 32'hC, 2'b10, 0, 0, 32'hCAFE_6655, 0, 3);

    if (SPLIT) begin
      push_bus(8'd2, 4'b0000, 32'h0); push_bus(8'd3, 4'b0000, 32'h0);
      do_req("lw9_split", 0, 32'h9, 2'b10, 0, 0, 32'h5544_3322, 0, 5);
      push_bus(8'd0, 4'b0000, 32'h0); push_bus(8'd1, 4'b0000, 32'h0);
      do_req("lh3_split", 0, 32'h3, 2'b01, 0, 0, 32'hFFFF_FFBE, 0, 5);
      push_bus(8'd255, 4'b1100, 32'hBEEF_0000); push_bus(8'd0, 4'b0011, 32'h0000_DEAD);
      do_req("sw_wrap", 1, 32'h3FE, 2'b10, 0, 32'hDEAD_BEEF, 0, 0, 5);
      push_bus(8'd0, 4'b0000, 32'h0);   do_req("lw0_wrap",   0, 32'h0,   2'b10, 0, 0, 32'hBEEF_DEAD, 0, 3);
      push_bus(8'd255, 4'b0000, 32'h0); do_req("lw3FC_wrap", 0, 32'h3FC, 2'b10, 0, 0, 32'hBEEF_0000, 0, 3);
    end else begin
      do_req("lw9_err",  0, 32'h9,   2'b10, 0, 0, 32'h0, 1, 1);
      do_req("lh3_err",  0, 32'h3,   2'b01, 0, 0, 32'h0, 1, 1);
      do_req("sw_wrap_err", 1, 32'h3FE, 2'b10, 0, 32'hDEAD_BEEF, 0, 1, 1);
      push_bus(8'd0, 4'b0000, 32'h0);   do_req("lw0_keep",   0, 32'h0,   2'b10, 0, 0, 32'hBEEF_CAFE, 0, 3);
      push_bus(8'd255, 4'b0000, 32'h0); do_req("lw3FC_keep", 0, 32'h3FC, 2'b10, 0, 0, 32'h0, 0, 3);
    end

    do_req("size11", 0, 32'h0, 2'b11, 0, 0, 32'h0, 1, 1);

    // Spurious ack while idle must not produce a completion
    @(negedge clk); spur_ack = 1'b1;
    @(negedge clk); spur_ack = 1'b0;
    check("spur_rvalid", core_if.o_rvalid, 0);
    check("spur_ready", core_if.o_ready, 1);
    @(negedge clk);
    check("spur_rvalid2", core_if.o_rvalid, 0);

    // Withheld ack: WAIT holds, then reset aborts the access
    ack_en = 1'b0;
    @(negedge clk);
    core_if.i_req = 1'b1; core_if.i_we = 1'b0; core_if.i_addr = 32'h4; core_if.i_size = 2'b10;
    @(posedge clk); #1;
    core_if.i_req = 1'b0;
    check("hang_sel", bus_if.o_sel, 1);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (core_if.o_rvalid || core_if.o_ready) seen = 1'b1;
    end
    check("hang_wait_holds", seen, 0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    check("rst_mid_ready", core_if.o_ready, 1);
    check("rst_mid_sel", bus_if.o_sel, 0);
    check("rst_mid_rvalid", core_if.o_rvalid, 0);
    @(negedge clk); rst = 1'b0; ack_en = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (core_if.o_rvalid || bus_if.o_sel) seen = 1'b1;
    end
    check("rst_mid_no_retry", seen, 0);
    push_bus(8'd1, 4'b0000, 32'h0); do_req("lw4_after_rst", 0, 32'h4, 2'b10, 0, 0, 32'h12A5_80FF, 0, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, observed timeout required finish");
    $fatal(1, "watchdog");
  end

endmodule
